// File: rtl/tag_match_sequencer_if.sv
// Request/result bus between the cache controller and the tag-match sequencer.
//   master : cache controller  (drives request, receives ready/done/result)
//   slave  : tag_match_sequencer
// Signals:
//   req_valid / req_ready : request handshake, transfer when both high on clk edge
//   req_tag               : tag to look up
//   set_tags              : stored tags of the indexed set, way k at [k*TAG_W +: TAG_W]
//   set_valid             : per-way valid bits
//   done                  : one-cycle pulse, result valid
//   hit / hit_way         : lookup result, held until the next accept
interface tag_match_sequencer_if #(
  parameter int unsigned TAG_W = 8,
  parameter int unsigned WAYS  = 4
);
  localparam int unsigned WAY_W = $clog2(WAYS);

  logic                   req_valid;
  logic                   req_ready;
  logic [TAG_W-1:0]       req_tag;
  logic [WAYS*TAG_W-1:0]  set_tags;
  logic [WAYS-1:0]        set_valid;
  logic                   done;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way;

  modport master (
    output req_valid, req_tag, set_tags, set_valid,
    input  req_ready, done, hit, hit_way
  );

  modport slave (
    input  req_valid, req_tag, set_tags, set_valid,
    output req_ready, done, hit, hit_way
  );
endinterface

// File: rtl/tag_match_sequencer.sv
// Sequential tag-lookup controller for the set-associative cache.
// Scans the ways of one set through a single shared AND-reduction comparator,
// one way per cycle, and reports hit/miss plus the lowest matching valid way.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset
//   bus      : request/result interface (slave side)
//   cmp_word : comparator operand, ~(captured tag ^ tag of way idx); zero outside COMPARE
//   cmp_and  : comparator result (&cmp_word), returned combinationally
// Parameters: TAG_W >= 2 (tag and comparator width), WAYS power of two in 2..16.
module tag_match_sequencer #(
  parameter int unsigned TAG_W = 8,
  parameter int unsigned WAYS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  tag_match_sequencer_if.slave  bus,
  output logic [TAG_W-1:0]      cmp_word,
  input  logic                  cmp_and
);

  localparam int unsigned WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WAY_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TAG_W-1:0] tags_q [WAYS];
  logic [TAG_W-1:0] tags_d [WAYS];
  logic [WAYS-1:0]  valid_q, valid_d;

  logic             ready_d;
  logic             done_d;
  logic             hit_d;
  logic [WAY_W-1:0] hit_way_d;
  logic [TAG_W-1:0] cmp_word_d;

  logic             way_match_c;
  logic [WAY_W-1:0] idx_next_c;

  // A way only counts as a hit when its stored line is valid.
  assign way_match_c = cmp_and & valid_q[idx_q];
  assign idx_next_c  = idx_q + WAY_W'(1);

  // Next-state and next-output logic. Outputs are precomputed for the coming
  // cycle so every output leaves a flop; cmp_word therefore tracks idx_d.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    tags_d     = tags_q;
    valid_d    = valid_q;
    hit_d      = bus.hit;
    hit_way_d  = bus.hit_way;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    cmp_word_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          tag_d   = bus.req_tag;
          valid_d = bus.set_valid;
          for (int unsigned k = 0; k < WAYS; k++) begin
            tags_d[k] = bus.set_tags[k*TAG_W +: TAG_W];
          end
          hit_d      = 1'b0;
          hit_way_d  = '0;
          idx_d      = '0;
          state_d    = ST_COMPARE;
          cmp_word_d = ~(bus.req_tag ^ bus.set_tags[TAG_W-1:0]);
        end else begin
          ready_d = 1'b1;
        end
      end

      ST_COMPARE: begin
        if (way_match_c) begin
          hit_d     = 1'b1;
          hit_way_d = idx_q;
          state_d   = ST_DONE;
          done_d    = 1'b1;
        end else if (idx_q == WAY_W'(WAYS - 1)) begin
          hit_d     = 1'b0;
          hit_way_d = '0;
          state_d   = ST_DONE;
          done_d    = 1'b1;
        end else begin
          idx_d      = idx_next_c;
          cmp_word_d = ~(tag_q ^ tags_q[idx_next_c]);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      tag_q         <= '0;
      valid_q       <= '0;
      for (int unsigned k = 0; k < WAYS; k++) begin
        tags_q[k] <= '0;
      end
      bus.req_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.hit       <= 1'b0;
      bus.hit_way   <= '0;
      cmp_word      <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tag_q         <= tag_d;
      valid_q       <= valid_d;
      tags_q        <= tags_d;
      bus.req_ready <= ready_d;
      bus.done      <= done_d;
      bus.hit       <= hit_d;
      bus.hit_way   <= hit_way_d;
      cmp_word      <= cmp_word_d;
    end
  end

endmodule

// File: tb/tb_tag_match_sequencer.sv
// Scoreboard bench for tag_match_sequencer (TAG_W=8, WAYS=4).
// The stimulus process pushes hand-computed expectations; a monitor pops them
// on each done pulse and also checks cmp_word every compare cycle.
module tb_tag_match_sequencer;

  localparam int unsigned TAG_W = 8;
  localparam int unsigned WAYS  = 4;
  localparam int unsigned WAY_W = 2;

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] tags;
    logic [3:0]  valid;
    logic        exp_hit;
    logic [1:0]  exp_way;
    int          exp_lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [TAG_W-1:0] cmp_word;
  logic             cmp_and;

  tag_match_sequencer_if #(.TAG_W(TAG_W), .WAYS(WAYS)) bus ();

  tag_match_sequencer #(.TAG_W(TAG_W), .WAYS(WAYS)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cmp_word (cmp_word),
    .cmp_and  (cmp_and)
  );

  // Stand-in for the shared and_wordgate comparator.
  assign cmp_and = &cmp_word;

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   en    = 1'b0;
  exp_t exp_q [$];
  int   acc_q [$];
  int   acc_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Accept stamps and reset flush, taken on the active edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end else if (bus.req_valid && bus.req_ready) begin
      acc_q.push_back(cyc);
      acc_log.push_back(cyc);
    end
    cyc++;
  end

  // Monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (en && !rst) begin
      if (bus.done) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("done_unexpected", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("hit", 32'(bus.hit), 32'(e.exp_hit));
          chk("hit_way", 32'(bus.hit_way), 32'(e.exp_way));
          chk("latency", 32'(cyc - a), 32'(e.exp_lat));
        end
        chk("ready_in_done", 32'(bus.req_ready), 32'd0);
        chk("cmp_word_in_done", 32'(cmp_word), 32'd0);
      end else if (acc_q.size() != 0) begin
        int k;
        k = cyc - acc_q[0] - 1;
        chk("ready_in_compare", 32'(bus.req_ready), 32'd0);
        if (k < 0 || k >= int'(WAYS) || exp_q.size() == 0) begin
          chk("compare_overrun", 32'(k), 32'(WAYS - 1));
        end else begin
          logic [7:0] w;
          w = ~(exp_q[0].tag ^ exp_q[0].tags[k*8 +: 8]);
          chk("cmp_word", 32'(cmp_word), 32'(w));
        end
      end else begin
        chk("cmp_word_idle", 32'(cmp_word), 32'd0);
      end
    end
  end

  // Drive a request from a falling edge and hold it until accepted.
  task automatic issue(input logic [7:0] t, input logic [31:0] ts, input logic [3:0] v,
                       input logic eh, input logic [1:0] ew, input int el);
    int n;
    exp_t e;
    e.tag = t; e.tags = ts; e.valid = v;
    e.exp_hit = eh; e.exp_way = ew; e.exp_lat = el;
    bus.req_tag   = t;
    bus.set_tags  = ts;
    bus.set_valid = v;
    bus.req_valid = 1'b1;
    exp_q.push_back(e);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'(n), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_tag   = '0;
    bus.set_tags  = '0;
    bus.set_valid = '0;

    // Reset held for two edges.
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_hit_way", 32'(bus.hit_way), 32'd0);
    chk("rst_cmp_word", 32'(cmp_word), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    // Hit on way 0, cmp_word = FF in its single compare cycle.
    issue(8'hA5, {8'h11, 8'h22, 8'h33, 8'hA5}, 4'b1111, 1'b1, 2'd0, 2);
    bus.req_valid = 1'b0;
    wait_idle();

    // Ways 2 and 3 both match: lowest wins after three compares.
    issue(8'h3C, {8'h3C, 8'h3C, 8'hC3, 8'h00}, 4'b1111, 1'b1, 2'd2, 4);
    bus.req_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("hold_hit", 32'(bus.hit), 32'd1);
    chk("hold_hit_way", 32'(bus.hit_way), 32'd2);

    // Tag matches only an invalid way: miss after all four ways.
    issue(8'h3C, {8'h03, 8'h02, 8'h3C, 8'h01}, 4'b1101, 1'b0, 2'd0, 5);
    bus.req_valid = 1'b0;
    wait_idle();

    // Only the last way is valid, all ways hold the tag: hit on way 3.
    issue(8'hC0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'b1000, 1'b1, 2'd3, 5);
    bus.req_valid = 1'b0;
    wait_idle();

    // Reset in the second compare cycle of a miss lookup.
    issue(8'h99, {8'h01, 8'h02, 8'h03, 8'h04}, 4'b1111, 1'b0, 2'd0, 5);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_hit", 32'(bus.hit), 32'd0);
    chk("midrst_hit_way", 32'(bus.hit_way), 32'd0);
    chk("midrst_cmp_word", 32'(cmp_word), 32'd0);
    repeat (8) @(negedge clk);

    // Back-to-back with req_valid held: hit way 1 (way 2 also matches), then a miss.
    issue(8'h5A, {8'h00, 8'h5A, 8'h5A, 8'hA5}, 4'b1111, 1'b1, 2'd1, 3);
    issue(8'h77, {8'h77, 8'hF7, 8'h75, 8'h76}, 4'b0111, 1'b0, 2'd0, 5);
    bus.req_valid = 1'b0;
    wait_idle();
    if (acc_log.size() >= 2) begin
      chk("b2b_gap", 32'(acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2]), 32'd4);
    end else begin
      chk("b2b_accepts", 32'(acc_log.size()), 32'd2);
    end
    @(negedge clk);
    chk("b2b_hold_hit", 32'(bus.hit), 32'd0);
    chk("b2b_hold_hit_way", 32'(bus.hit_way), 32'd0);
    chk("final_ready", 32'(bus.req_ready), 32'd1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/tag_match_sequencer.md
# tag_match_sequencer

Sequential tag-lookup controller for the set-associative cache. It shares a single reduction-AND comparator (`and_wordgate` instance, width `TAG_W`) across all ways of the selected set. Each cycle it drives the bitwise-XNOR of the request tag and one way's stored tag into the comparator, then samples the reduced result. It reports hit/miss and the hit way to the cache controller over a valid/ready request and one-cycle done pulse.

## Interface
- `TAG_W`, 8, tag width; also the width of the shared comparator; must be ≥ 2.
- `WAYS`, 4, associativity; power of two, 2..16.
- `WAY_W`, $clog2(WAYS), width of way index.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset; one clock; sampled on rising edge of `clk`.
- `req_valid`  in  1  lookup request present.
- `req_ready`  out  1  sequencer can accept a request (IDLE only).
- `req_tag`  in  TAG_W  tag to look up; sampled on accept.
- `set_tags`  in  WAYS*TAG_W  stored tags of the indexed set; way k at bits [k*TAG_W +: TAG_W]; sampled on accept.
- `set_valid`  in  WAYS  valid bit per way; sampled on accept.
- `cmp_word`  out  TAG_W  to comparator input: ~(tag_q ^ tag_of_way[idx]); all-zero outside COMPARE.
- `cmp_and`  in  1  comparator output (AND-reduction of `cmp_word`), combinational return.
- `done`  out  1  one-cycle pulse: lookup result valid.
- `hit`  out  1  registered result; held from `done` until next accept.
- `hit_way`  out  WAY_W  way that hit; 0 on miss; held like `hit`.

## Operation
- States: IDLE, COMPARE, DONE. Way counter `idx` (WAY_W bits).
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: capture `req_tag`, `set_tags`, `set_valid`; clear `hit`/`hit_way`; `idx`←0; go COMPARE.
- COMPARE:
  - `req_ready`=0; `cmp_word` driven from captured data for way `idx`.
  - Way matches iff `cmp_and`=1 AND `valid_q[idx]`=1.
  - Match: `hit`←1, `hit_way`←`idx`, go DONE.
  - No match and `idx`=WAYS-1: `hit`←0, `hit_way`←0, go DONE.
  - Otherwise: `idx`←`idx`+1, stay in COMPARE.
- DONE:
  - `done`=1 for exactly this cycle; `req_ready`=0; next state IDLE.
- Priority: ways are scanned 0 upward and the scan terminates at the first match, so the lowest-index matching valid way wins on multiple matches.
- Invalid ways: a tag match on a way with valid=0 is a non-match; the way still costs one COMPARE cycle (no skipping).
- Inputs other than `req_valid` are ignored outside the accept cycle. Changes to `set_tags`/`req_tag` during COMPARE have no effect.
- `req_valid` while not ready is ignored, not queued. The requester must hold it until accepted.

## Timing
- Reset values:
  - state=IDLE, `idx`=0, captured regs=0.
  - `req_ready`=1, `done`=0, `hit`=0, `hit_way`=0, `cmp_word`=0.
- `rst` in any state (including mid-COMPARE or DONE) aborts the lookup next edge. No `done` is issued for the aborted request.
- Latency, with the accept edge as E0:
  - Way k is compared in the cycle after E0+k.
  - Hit on way k: `done` high in cycle after edge E0+k+1, i.e. k+2 cycles after accept.
  - Miss: `done` WAYS+1 cycles after accept.
- Throughput: next accept at earliest on the edge ending the cycle after DONE (`req_ready` is high in the IDLE cycle following DONE). Minimum request spacing is k+3 cycles.
- `cmp_and` is assumed combinationally valid in the same cycle as `cmp_word`. No register sits between them.
- `hit`/`hit_way` change only on accept (clear), on a COMPARE decision, or on reset.

## Test plan
- Reset: assert `rst` 2 cycles -> `req_ready`=1, `done`=0, `hit`=0, `hit_way`=0, `cmp_word`=0.
- Hit way 0: TAG_W=8, WAYS=4, `req_tag`=8'hA5, way0 tag=8'hA5 valid=1 -> `done` 2 cycles after accept, `hit`=1, `hit_way`=0. During COMPARE, `cmp_word`=8'hFF.
- Hit way 2 with multi-match: ways 2 and 3 both hold 8'h3C valid, `req_tag`=8'h3C -> `done` 4 cycles after accept, `hit`=1, `hit_way`=2. Exactly 3 COMPARE cycles.
- Miss and invalid match: way1 tag=8'h3C valid=0, no other match -> `done` 5 cycles after accept, `hit`=0, `hit_way`=0.
- Reset mid-operation: accept a miss lookup, assert `rst` in the 2nd COMPARE cycle -> IDLE next cycle, no `done` pulse, outputs at reset values.
- Back-to-back: hold `req_valid` high with a hit-way-1 request then a miss -> second accept occurs exactly in the IDLE cycle after the first `done`. `req_ready` is never high during COMPARE or DONE; results are independent.
